// File: rtl/core_sequencer_r32i_pkg.sv
// Purpose : shared state encoding and width helpers for the RV32I multi-cycle sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: seqState_t (3-bit state enum), TIMEOUT_W, cntWidth() for the memory-wait counter.
package sequencerPkgR32I;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_FAULT     = 3'd6
   } seqState_t;

   localparam int MEM_TIMEOUT_DEF = 255;
   localparam int TIMEOUT_W       = $clog2(MEM_TIMEOUT_DEF + 1);

   // Wait counter is never narrower than 8 bits, wider if the timeout needs it.
   function automatic int cntWidth(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/core_sequencer_r32i_perf.sv
// Purpose : free-running 64-bit cycle and retired-instruction counters (wrap modulo 2^64).
// Latency : counts appear one clock after the qualifying cycle.
// Backpr. : none; enables are sampled every cycle.
// Ports   : clk, reset (async, active-high), i_cycle_en, i_instret_en,
//           o_cycle_count[63:0], o_instret_count[63:0].
module perfCountersR32I (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_cycle_en,
   input  logic        i_instret_en,
   output logic [63:0] o_cycle_count,
   output logic [63:0] o_instret_count
);

   logic [63:0] r_cycle;
   logic [63:0] r_instret;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         if (i_cycle_en)   r_cycle   <= r_cycle + 64'd1;
         if (i_instret_en) r_instret <= r_instret + 64'd1;
      end
   end

   assign o_cycle_count   = r_cycle;
   assign o_instret_count = r_instret;

endmodule

// File: rtl/core_sequencer_r32i.sv
// Purpose : multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Latency : ALU op 4 cycles + fetch wait; load/store 5 cycles + fetch wait + data wait.
// Backpr. : InsReq/DataReq held until InsReady/DataReady; MEM_TIMEOUT waiting cycles -> FAULT.
// Ports   : clk, reset (async, active-high), Run, InsReady, DataReady, decoder flags
//           (RegWriteControl, RAMRead, RAMWriteControl, TestBranch, AlwaysBranch), BranchCond;
//           outputs InsReq, IRLoad, DataReq, DataWe, RegWriteEn, PCBranch, PCIncrement,
//           InstRetired, BusFault (sticky), StateOut[2:0].
// Config  : PERF_COUNTERS_EN adds CycleCount[63:0] and InstretCount[63:0].
module core_sequencer_r32i
   import sequencerPkgR32I::*;
#(
   parameter int dataW       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Run,
   input  logic        InsReady,
   input  logic        DataReady,
   input  logic        RegWriteControl,
   input  logic        RAMRead,
   input  logic        RAMWriteControl,
   input  logic        TestBranch,
   input  logic        AlwaysBranch,
   input  logic        BranchCond,
   output logic        InsReq,
   output logic        IRLoad,
   output logic        DataReq,
   output logic        DataWe,
   output logic        RegWriteEn,
   output logic        PCBranch,
   output logic        PCIncrement,
   output logic        InstRetired,
   output logic        BusFault,
   output logic [2:0]  StateOut
`ifdef PERF_COUNTERS_EN
   ,
   output logic [63:0] CycleCount,
   output logic [63:0] InstretCount
`endif
);

   localparam int              CNT_W    = cntWidth(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // The sequencer is width-agnostic; dataW only has to match the datapath it controls.
   if (dataW != 32) begin : g_non_rv32_width
   end

   seqState_t        r_state;
   seqState_t        w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_fault;
   logic             w_wait;
   logic             w_timeout;
   logic             w_pc_branch;

   // The waiting cycle that would bring the count up to MEM_TIMEOUT is the last one allowed.
   assign w_timeout   = (MEM_TIMEOUT != 0) && (r_cnt == CNT_LAST);
   assign w_pc_branch = AlwaysBranch | (TestBranch & BranchCond);

   always_comb begin
      w_next = r_state;
      w_wait = 1'b0;
      case (r_state)
         S_IDLE:      if (Run) w_next = S_FETCH;
         S_FETCH: begin
            if (InsReady) begin
               w_next = S_DECODE;
            end else begin
               w_wait = 1'b1;
               if (w_timeout) w_next = S_FAULT;
            end
         end
         S_DECODE:    w_next = S_EXECUTE;
         S_EXECUTE:   w_next = (RAMRead | RAMWriteControl) ? S_MEMORY : S_WRITEBACK;
         S_MEMORY: begin
            if (DataReady) begin
               w_next = S_WRITEBACK;
            end else begin
               w_wait = 1'b1;
               if (w_timeout) w_next = S_FAULT;
            end
         end
         S_WRITEBACK: w_next = Run ? S_FETCH : S_IDLE;
         S_FAULT:     w_next = S_FAULT;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      InsReq      = 1'b0;
      IRLoad      = 1'b0;
      DataReq     = 1'b0;
      DataWe      = 1'b0;
      RegWriteEn  = 1'b0;
      PCBranch    = 1'b0;
      PCIncrement = 1'b0;
      InstRetired = 1'b0;
      case (r_state)
         S_FETCH: begin
            InsReq = 1'b1;
            IRLoad = InsReady;
         end
         S_MEMORY: begin
            DataReq = 1'b1;
            // Stores also raise RAMRead, so the write flag decides direction.
            DataWe  = RAMWriteControl;
         end
         S_WRITEBACK: begin
            RegWriteEn  = RegWriteControl & ~RAMWriteControl;
            PCBranch    = w_pc_branch;
            PCIncrement = ~w_pc_branch;
            InstRetired = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bus_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         // Any state change clears the counter, so it starts at 0 on entry to FETCH/MEMORY.
         if (w_next != r_state)
            r_cnt <= '0;
         else if (w_wait && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + 1'b1;
         if ((w_next == S_FAULT) && (r_state != S_FAULT))
            r_bus_fault <= 1'b1;
      end
   end

   assign BusFault = r_bus_fault;
   assign StateOut = r_state;

`ifdef PERF_COUNTERS_EN
   logic w_cycle_en;
   assign w_cycle_en = (r_state != S_IDLE) && (r_state != S_FAULT);

   perfCountersR32I u_perf (
      .clk             (clk),
      .reset           (reset),
      .i_cycle_en      (w_cycle_en),
      .i_instret_en    (InstRetired),
      .o_cycle_count   (CycleCount),
      .o_instret_count (InstretCount)
   );
`endif

endmodule

// File: tb/tb_core_sequencer_r32i.sv
// Purpose : directed cycle-by-cycle vectors for core_sequencer_r32i (MEM_TIMEOUT=4) plus async reset sequences.
// Latency : inputs change on the falling edge; outputs compared 1 time unit later.
// Backpr. : InsReady/DataReady stimulus provides zero-wait, delayed and never-ready memory.
module tb_core_sequencer_r32i;

   logic        clk = 1'b0;
   logic        reset;
   logic        Run, InsReady, DataReady;
   logic        RegWriteControl, RAMRead, RAMWriteControl;
   logic        TestBranch, AlwaysBranch, BranchCond;
   logic        InsReq, IRLoad, DataReq, DataWe, RegWriteEn;
   logic        PCBranch, PCIncrement, InstRetired, BusFault;
   logic [2:0]  StateOut;
`ifdef PERF_COUNTERS_EN
   logic [63:0] CycleCount, InstretCount;
`endif

   always #5 clk = ~clk;

   core_sequencer_r32i #(.dataW(32), .MEM_TIMEOUT(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .Run             (Run),
      .InsReady        (InsReady),
      .DataReady       (DataReady),
      .RegWriteControl (RegWriteControl),
      .RAMRead         (RAMRead),
      .RAMWriteControl (RAMWriteControl),
      .TestBranch      (TestBranch),
      .AlwaysBranch    (AlwaysBranch),
      .BranchCond      (BranchCond),
      .InsReq          (InsReq),
      .IRLoad          (IRLoad),
      .DataReq         (DataReq),
      .DataWe          (DataWe),
      .RegWriteEn      (RegWriteEn),
      .PCBranch        (PCBranch),
      .PCIncrement     (PCIncrement),
      .InstRetired     (InstRetired),
      .BusFault        (BusFault),
      .StateOut        (StateOut)
`ifdef PERF_COUNTERS_EN
      ,
      .CycleCount      (CycleCount),
      .InstretCount    (InstretCount)
`endif
   );

   // {InsReq,IRLoad,DataReq,DataWe}_{RegWriteEn,PCBranch,PCIncrement,InstRetired}_{BusFault}_{StateOut}
   logic [11:0] w_outs;
   assign w_outs = {InsReq, IRLoad, DataReq, DataWe, RegWriteEn, PCBranch, PCIncrement,
                    InstRetired, BusFault, StateOut};

   // in: {Run,InsReady,DataReady}_{RegWriteControl,RAMRead,RAMWriteControl}_{TestBranch,AlwaysBranch,BranchCond}
   typedef struct packed {
      logic [8:0]  in;
      logic [11:0] exp;
   } vec_t;

   localparam int NV = 44;
   vec_t tbl [NV];

   int n_checks = 0;
   int n_errors = 0;

   function automatic vec_t mk(input logic [8:0] i, input logic [11:0] e);
      vec_t v;
      v.in  = i;
      v.exp = e;
      return v;
   endfunction

   task automatic drive(input logic [8:0] v);
      {Run, InsReady, DataReady, RegWriteControl, RAMRead, RAMWriteControl,
       TestBranch, AlwaysBranch, BranchCond} = v;
   endtask

   task automatic check12(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: outputs %b, expected %b", name, got, exp);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: value %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end of the test");
      $fatal(1);
   end

   initial begin
      // ALU op, zero-wait fetch; cycle 1 is IDLE, IRLoad in cycle 2, WB in cycle 5.
      tbl[0]  = mk(9'b110_100_000, 12'b0000_0000_0_000);  // IDLE, InsReady ignored
      tbl[1]  = mk(9'b110_100_000, 12'b1100_0000_0_001);  // FETCH, ready same cycle
      tbl[2]  = mk(9'b100_100_000, 12'b0000_0000_0_010);  // DECODE
      tbl[3]  = mk(9'b100_100_000, 12'b0000_0000_0_011);  // EXECUTE
      tbl[4]  = mk(9'b100_100_000, 12'b0000_1011_0_101);  // WB: RegWriteEn, PC+4, retire
      // Load, fetch waits once, DataReady after 3 waiting cycles.
      tbl[5]  = mk(9'b100_110_000, 12'b1000_0000_0_001);  // FETCH wait
      tbl[6]  = mk(9'b110_110_000, 12'b1100_0000_0_001);  // FETCH ready
      tbl[7]  = mk(9'b101_110_000, 12'b0000_0000_0_010);  // DECODE, DataReady ignored
      tbl[8]  = mk(9'b101_110_000, 12'b0000_0000_0_011);  // EXECUTE, DataReady ignored
      tbl[9]  = mk(9'b100_110_000, 12'b0010_0000_0_100);  // MEMORY wait 1
      tbl[10] = mk(9'b100_110_000, 12'b0010_0000_0_100);  // MEMORY wait 2
      tbl[11] = mk(9'b100_110_000, 12'b0010_0000_0_100);  // MEMORY wait 3
      tbl[12] = mk(9'b101_110_000, 12'b0010_0000_0_100);  // MEMORY ready at count 3 (last allowed)
      tbl[13] = mk(9'b100_110_000, 12'b0000_1011_0_101);  // WB: load writes rd
      // Store, zero-wait data memory.
      tbl[14] = mk(9'b110_111_000, 12'b1100_0000_0_001);
      tbl[15] = mk(9'b100_111_000, 12'b0000_0000_0_010);
      tbl[16] = mk(9'b100_111_000, 12'b0000_0000_0_011);
      tbl[17] = mk(9'b101_111_000, 12'b0011_0000_0_100);  // MEMORY: DataReq+DataWe
      tbl[18] = mk(9'b100_111_000, 12'b0000_0011_0_101);  // WB: no RegWriteEn for store
      // Conditional branch, not taken.
      tbl[19] = mk(9'b110_000_100, 12'b1100_0000_0_001);
      tbl[20] = mk(9'b100_000_100, 12'b0000_0000_0_010);
      tbl[21] = mk(9'b100_000_100, 12'b0000_0000_0_011);
      tbl[22] = mk(9'b100_000_100, 12'b0000_0011_0_101);  // PCIncrement
      // Conditional branch, taken.
      tbl[23] = mk(9'b110_000_101, 12'b1100_0000_0_001);
      tbl[24] = mk(9'b100_000_101, 12'b0000_0000_0_010);
      tbl[25] = mk(9'b100_000_101, 12'b0000_0000_0_011);
      tbl[26] = mk(9'b100_000_101, 12'b0000_0101_0_101);  // PCBranch
      // JAL: always branch, writes link register.
      tbl[27] = mk(9'b110_100_010, 12'b1100_0000_0_001);
      tbl[28] = mk(9'b100_100_010, 12'b0000_0000_0_010);
      tbl[29] = mk(9'b100_100_010, 12'b0000_0000_0_011);
      tbl[30] = mk(9'b100_100_010, 12'b0000_1101_0_101);  // PCBranch + RegWriteEn
      // Run dropped in EXECUTE: retires, then parks in IDLE.
      tbl[31] = mk(9'b110_100_000, 12'b1100_0000_0_001);
      tbl[32] = mk(9'b100_100_000, 12'b0000_0000_0_010);
      tbl[33] = mk(9'b000_100_000, 12'b0000_0000_0_011);
      tbl[34] = mk(9'b000_100_000, 12'b0000_1011_0_101);
      tbl[35] = mk(9'b000_100_000, 12'b0000_0000_0_000);  // IDLE
      tbl[36] = mk(9'b010_100_000, 12'b0000_0000_0_000);  // IDLE, InsReady ignored
      // Fetch timeout: 4 waiting cycles then FAULT, sticky.
      tbl[37] = mk(9'b100_000_000, 12'b0000_0000_0_000);
      tbl[38] = mk(9'b100_000_000, 12'b1000_0000_0_001);
      tbl[39] = mk(9'b100_000_000, 12'b1000_0000_0_001);
      tbl[40] = mk(9'b100_000_000, 12'b1000_0000_0_001);
      tbl[41] = mk(9'b100_000_000, 12'b1000_0000_0_001);
      tbl[42] = mk(9'b110_000_000, 12'b0000_0000_1_110);  // FAULT, InsReq dropped
      tbl[43] = mk(9'b111_111_111, 12'b0000_0000_1_110);  // FAULT ignores everything

      reset = 1'b1;
      drive(9'b111_111_111);
      @(negedge clk);
      @(negedge clk);
      #1;
      check12("reset_hold", w_outs, 12'b0);
`ifdef PERF_COUNTERS_EN
      check64("reset_cycle_count", CycleCount, 64'd0);
`endif

      @(negedge clk);
      reset = 1'b0;
      drive(9'b0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i].in);
         #1;
         check12($sformatf("vec_c%0d", i + 1), w_outs, tbl[i].exp);
      end

`ifdef PERF_COUNTERS_EN
      // 7 retirements; active cycles c2..c35 (34) plus fetch waits c39..c42 (4).
      check64("instret_count", InstretCount, 64'd7);
      check64("cycle_count", CycleCount, 64'd38);
`endif

      // Reset out of FAULT clears BusFault.
      @(negedge clk);
      reset = 1'b1;
      drive(9'b0);
      #1;
      check12("reset_from_fault", w_outs, 12'b0);

      @(negedge clk);
      reset = 1'b0;
      drive(9'b100_000_000);
      @(negedge clk);
      #1;
      check12("fetch_after_reset", w_outs, 12'b1000_0000_0_001);

      // Asynchronous reset mid-cycle while a fetch is outstanding.
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check12("reset_mid_fetch", w_outs, 12'b0);
`ifdef PERF_COUNTERS_EN
      check64("reset_mid_fetch_instret", InstretCount, 64'd0);
`endif

      @(negedge clk);
      reset = 1'b0;
      drive(9'b110_100_000);
      @(negedge clk);
      #1;
      check12("refetch_after_reset", w_outs, 12'b1100_0000_0_001);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
